// File: rtl/sdp_pkg.sv
// rtl/sdp_pkg.sv - shared types and constants for the serial debug port responder
//
// Purpose: frame state encoding, command encoding, ack length and status
// codes used by sdp_slave.
package sdp_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_STRB,
    S_DATA,
    S_PAR,
    S_STOP,
    S_TURN,
    S_ACK,
    S_RDATA,
    S_DONE
  } sdp_state_t;

  localparam logic SDP_CMD_WR     = 1'b1;
  localparam logic SDP_CMD_RD     = 1'b0;
  localparam int   SDP_ACK_BITS   = 2;
  localparam logic SDP_STATUS_OK  = 1'b0;
  localparam logic SDP_STATUS_ERR = 1'b1;

endpackage

// File: rtl/sdp_edge_sync.sv
// rtl/sdp_edge_sync.sv - synchroniser and edge detector for the SDP clock and line
//
// Purpose: brings sdp_ck and sdp_di into the clk domain through equal-depth
// chains, so a detected ck edge and the synchronised di are time-aligned.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   ck, di       raw serial clock and line input
//   ck_rise      one-cycle pulse on a synchronised ck rising edge
//   ck_fall      one-cycle pulse on a synchronised ck falling edge
//   di_sync      synchronised line value
module sdp_edge_sync import sdp_pkg::*; #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ck,
  input  logic di,
  output logic ck_rise,
  output logic ck_fall,
  output logic di_sync
);

  logic [SYNC_STAGES-1:0] ck_q;
  logic [SYNC_STAGES-1:0] di_q;
  logic                   ck_prev;

  // di resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_q    <= '0;
      di_q    <= '1;
      ck_prev <= 1'b0;
    end else begin
      ck_q    <= {ck_q[SYNC_STAGES-2:0], ck};
      di_q    <= {di_q[SYNC_STAGES-2:0], di};
      ck_prev <= ck_q[SYNC_STAGES-1];
    end
  end

  assign ck_rise = ck_q[SYNC_STAGES-1] & ~ck_prev;
  assign ck_fall = ~ck_q[SYNC_STAGES-1] & ck_prev;
  assign di_sync = di_q[SYNC_STAGES-1];

endmodule

// File: rtl/sdp_slave.sv
// rtl/sdp_slave.sv - serial debug port responder acting as a memory-bus master
//
// Purpose: decodes host SDP request frames (sampled on sdp_ck falling edges),
// issues one memory read or write per accepted frame, and shifts ack, status
// or read data back on the shared line (changed on sdp_ck rising edges).
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   sdp_ck, sdp_di     host serial clock and line input
//   sdp_do, sdp_doen   line output value and active-low output enable
//   mem_req_*          bus request (valid/ready handshake, we, addr, wdata, wstrb)
//   mem_rsp_*          one-cycle bus response with read data and error flag
module sdp_slave import sdp_pkg::*; #(
  parameter int N_AW        = 32,
  parameter int N_DW        = 32,
  parameter int N_DM        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_EDGES  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sdp_ck,
  input  logic            sdp_di,
  output logic            sdp_do,
  output logic            sdp_doen,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_we,
  output logic [N_AW-1:0] mem_req_addr,
  output logic [N_DW-1:0] mem_req_wdata,
  output logic [N_DM-1:0] mem_req_wstrb,
  input  logic            mem_rsp_valid,
  input  logic [N_DW-1:0] mem_rsp_rdata,
  input  logic            mem_rsp_err
);

  localparam int CW = $clog2(((N_AW > N_DW) ? N_AW : N_DW) + 1);
  localparam int TW = $clog2(TURN_EDGES + 1);

  logic            ck_rise;
  logic            ck_fall;
  logic            di;
  sdp_state_t      state;
  sdp_state_t      state_next;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   turn_cnt;
  logic            par_bit;
  logic            bus_wait;
  logic            err;
  logic [N_DW-1:0] rsp_data;
  logic            rsp_par;

  logic bus_done;
  logic turn_done;
  logic last_bit;
  logic par_calc;
  logic par_ok;
  logic rsp_take;

  sdp_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .ck      (sdp_ck),
    .di      (sdp_di),
    .ck_rise (ck_rise),
    .ck_fall (ck_fall),
    .di_sync (di)
  );

  assign bus_done  = !mem_req_valid && !bus_wait;
  assign turn_done = (turn_cnt == TW'(TURN_EDGES));
  assign last_bit  = (cnt == CW'(1));
  // Write parity folds in a constant 1 so an all-zero write frame is not all zeros.
  assign par_calc  = (mem_req_we == SDP_CMD_WR) ? ~(^mem_req_addr ^ ^mem_req_wdata)
                                                : ^mem_req_addr;
  assign par_ok    = (par_bit == par_calc);
  // A response may coincide with the accepting cycle; take it either way.
  assign rsp_take  = mem_rsp_valid && (bus_wait || (mem_req_valid && mem_req_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (ck_fall && !di) state_next = S_CMD;
      S_CMD:   if (ck_fall) state_next = S_ADDR;
      S_ADDR:  if (ck_fall && last_bit)
                 state_next = (mem_req_we == SDP_CMD_WR) ? S_STRB : S_PAR;
      S_STRB:  if (ck_fall && last_bit) state_next = S_DATA;
      S_DATA:  if (ck_fall && last_bit) state_next = S_PAR;
      S_PAR:   if (ck_fall) state_next = S_STOP;
      S_STOP:  if (ck_fall) state_next = di ? S_TURN : S_IDLE;
      S_TURN:  if (ck_rise && turn_done && bus_done) state_next = S_ACK;
      S_ACK:   if (ck_rise && cnt == '0)
                 state_next = (mem_req_we == SDP_CMD_WR) ? S_DONE : S_RDATA;
      S_RDATA: if (ck_rise && cnt == '0) state_next = S_DONE;
      S_DONE:  if (ck_rise) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdp_do        <= 1'b1;
      sdp_doen      <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_req_we    <= SDP_CMD_RD;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
      cnt           <= '0;
      turn_cnt      <= '0;
      par_bit       <= 1'b0;
      bus_wait      <= 1'b0;
      err           <= 1'b0;
      rsp_data      <= '0;
      rsp_par       <= 1'b0;
    end else begin
      // Bus side runs alongside the line turnaround.
      if (mem_req_valid && mem_req_ready) begin
        mem_req_valid <= 1'b0;
        bus_wait      <= !mem_rsp_valid;
      end
      if (rsp_take) begin
        bus_wait <= 1'b0;
        rsp_data <= mem_rsp_rdata;
        err      <= mem_rsp_err;
        rsp_par  <= ^mem_rsp_rdata ^ mem_rsp_err;
      end

      case (state)
        S_CMD: if (ck_fall) begin
          mem_req_we <= di;
          cnt        <= CW'(N_AW);
        end
        S_ADDR: if (ck_fall) begin
          mem_req_addr <= {mem_req_addr[N_AW-2:0], di};
          cnt          <= last_bit ? CW'(N_DM) : cnt - CW'(1);
        end
        S_STRB: if (ck_fall) begin
          mem_req_wstrb <= {mem_req_wstrb[N_DM-2:0], di};
          cnt           <= last_bit ? CW'(N_DW) : cnt - CW'(1);
        end
        S_DATA: if (ck_fall) begin
          mem_req_wdata <= {mem_req_wdata[N_DW-2:0], di};
          cnt           <= cnt - CW'(1);
        end
        S_PAR: if (ck_fall) par_bit <= di;
        S_STOP: if (ck_fall && di) begin
          turn_cnt <= '0;
          if (par_ok) begin
            mem_req_valid <= 1'b1;
            err           <= 1'b0;
          end else begin
            // Rejected frame: zero data with forced-bad response parity.
            err      <= 1'b1;
            rsp_data <= '0;
            rsp_par  <= 1'b1;
          end
        end
        S_TURN: if (ck_rise) begin
          if (!turn_done) begin
            turn_cnt <= turn_cnt + TW'(1);
          end else if (bus_done) begin
            sdp_doen <= 1'b0;
            sdp_do   <= 1'b0;
            cnt      <= CW'(SDP_ACK_BITS - 1);
          end
        end
        S_ACK: if (ck_rise) begin
          if (cnt != '0) begin
            sdp_do <= 1'b0;
            cnt    <= cnt - CW'(1);
          end else if (mem_req_we == SDP_CMD_WR) begin
            sdp_do <= err ? SDP_STATUS_ERR : SDP_STATUS_OK;
          end else begin
            sdp_do   <= rsp_data[N_DW-1];
            rsp_data <= {rsp_data[N_DW-2:0], 1'b0};
            cnt      <= CW'(N_DW - 1);
          end
        end
        S_RDATA: if (ck_rise) begin
          if (cnt != '0) begin
            sdp_do   <= rsp_data[N_DW-1];
            rsp_data <= {rsp_data[N_DW-2:0], 1'b0};
            cnt      <= cnt - CW'(1);
          end else begin
            sdp_do <= rsp_par;
          end
        end
        S_DONE: if (ck_rise) begin
          sdp_doen <= 1'b1;
          sdp_do   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sdp_slave.md
Name: sdp_slave

Overview:
- Target-side serial debug port (SDP) responder that decodes host-initiated SDP frames sampled from an externally supplied sdp_ck.
- Converts each frame into one memory-bus read or write and serialises the ack, status and read data back on the shared line.
- Sits between the chip pad (tri-state split into di/do/doen) and the internal memory bus as a bus master.
- Runs entirely on the system clock; sdp_ck and the line are oversampled.

Parameters:
- N_AW, 32: address bits per frame.
- N_DW, 32: data bits per frame.
- N_DM, 4: write-strobe bits per write frame.
- SYNC_STAGES, 2: synchroniser depth on sdp_ck and sdp_di.
- TURN_EDGES, 2: sdp_ck rising edges after the stop-bit sample before the responder may drive.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sdp_ck  in  1  host serial clock; half period must be at least SYNC_STAGES+2 clk cycles
- sdp_di  in  1  line input from pad
- sdp_do  out  1  line output value
- sdp_doen  out  1  active-low output enable; 1 releases the line (pad pull-up gives 1)
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus request accepted
- mem_req_we  out  1  1 = write
- mem_req_addr  out  N_AW  address
- mem_req_wdata  out  N_DW  write data
- mem_req_wstrb  out  N_DM  byte strobes
- mem_rsp_valid  in  1  one-cycle response pulse
- mem_rsp_rdata  in  N_DW  read data
- mem_rsp_err  in  1  bus error

Behaviour:
- Reset (async, all flops): sdp_doen=1, sdp_do=1, mem_req_valid=0, mem_req_we=0, addr/wdata/wstrb=0, state IDLE.
- Line timing:
  - Synchronise sdp_ck and sdp_di, then detect edges of the synchronised sdp_ck.
  - Host bits are sampled on the detected falling edge.
  - Responder outputs change only on the detected rising edge, so they are stable at the host's falling-edge sample.
- Request frame, one bit per sdp_ck period, MSB first:
  - start bit: 0
  - cmd bit: 1 = write, 0 = read
  - addr[N_AW-1:0]
  - write only: wstrb[N_DM-1:0], then data[N_DW-1:0]
  - parity bit
  - stop bit: 1
- Request parity:
  - write frame: parity = 1 ^ (^addr) ^ (^data); strobes are excluded.
  - read frame: parity = ^addr.
- State machine:
  - IDLE: wait for a 0 sample, which is the start bit.
  - IDLE -> CMD -> ADDR -> (STRB -> DATA if write) -> PAR -> STOP.
  - STOP = 0 is a framing error: return to IDLE, issue no bus access, send no response.
  - STOP = 1 -> BUS if parity is good; -> TURN if parity is bad (no bus access, error flag set).
  - BUS: assert mem_req_valid and hold addr/we/wdata/wstrb stable until mem_req_ready is sampled 1, then wait for mem_rsp_valid; capture rdata and err.
  - TURN: count TURN_EDGES rising edges since the stop sample. This runs concurrently with BUS. Leave TURN only when both the count and the bus response are complete. The line stays released for an unbounded bus stall.
  - ACK: on successive rising edges drive 0, 0 (sdp_doen=0).
  - Write, after ACK: next rising edge drives status (0 ok, 1 = parity error or mem_rsp_err).
  - Read, after ACK: drive rdata MSB first on N_DW rising edges, then the response parity bit.
    - Response parity = ^rdata, inverted if parity error or mem_rsp_err.
    - On a read parity error, rdata is driven as 0.
  - DONE: next rising edge sets sdp_doen=1, sdp_do=1 -> IDLE.
- Bit counter width: clog2(max(N_AW, N_DW)+1); it reloads at each field boundary.
- While receiving, sdp_doen stays 1.
- A start bit arriving while not in IDLE is ignored.
- Exactly one mem_req_valid handshake per accepted frame.

Decomposition:
- Package sdp_pkg:
  - state enum
  - SDP_CMD_WR=1, SDP_CMD_RD=0
  - SDP_ACK_BITS=2
  - SDP_STATUS_OK=0, SDP_STATUS_ERR=1
- Sub-module sdp_edge_sync: SYNC_STAGES synchroniser for sdp_ck and sdp_di, plus one-cycle ck_rise/ck_fall pulses and the synchronised di.

Test Plan:
- Write addr 0x1000_0004, data 0xA5A5_5A5A, correct parity -> one request (we=1, addr 0x1000_0004, wdata 0xA5A5_5A5A, wstrb 0xF); host samples ack 0, 0, then status 0.
- Read addr 0x2000_0000, bus returns 0x1234_5678 -> line carries ack 0, 0, bits of 0x12345678 MSB first, then parity 1.
- Write frame with flipped parity bit -> no mem_req_valid; response ack 0, 0, then status 1.
- Read with mem_rsp_valid delayed 50 clk and mem_rsp_err=1 -> line released (doen=1) until the response, then ack 0, 0, data, then parity = inverted ^rdata.
- Stop bit sent as 0 -> no request, no drive, IDLE; the next valid write completes normally.
- rst_n pulsed low mid-ADDR, and again while BUS is pending -> outputs take reset values immediately; the subsequent read frame completes correctly.
